// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// IMEM_DEPTH mirrors the instruction memory data_size define; keep the two in step.
package imem_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned IMEM_DEPTH = 65536;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_WRITE   = 4'd5,
    ST_CSUM_HI = 4'd6,
    ST_CSUM_LO = 4'd7,
    ST_DONE    = 4'd8,
    ST_ERROR   = 4'd9
  } state_t;

  // One past the last word an image of n words would touch, at 17 bits so it cannot wrap.
  function automatic logic [WORD_W:0] range_end(input logic [WORD_W-1:0] base,
                                                input logic [WORD_W-1:0] n);
    return {1'b0, base} + {1'b0, n};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction memory write port of the program loader.
// master: the loader side; slave: byte source / instruction memory side.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [WORD_W-1:0] load_address;
  logic [WORD_W-1:0] instruction_in;
  logic              instruction_write;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, load_address, instruction_in, instruction_write
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, load_address, instruction_in, instruction_write
  );

endinterface

// File: rtl/imem_loader_timeout.sv
// Idle watchdog for the loader: counts clocks while enabled, restarts on clear,
// and saturates at TIMEOUT_CYC where expired is raised.
module imem_loader_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] count;

  // Idle clock counter; held at zero whenever the loader is not mid-load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: assembles big-endian 16-bit words from a byte
// stream and writes them into instruction memory, holding the CPU meanwhile.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a 16-bit
// modular-sum trailer after the data words.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned DEPTH       = IMEM_DEPTH,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [WORD_W-1:0]   words_loaded
);

  localparam logic [WORD_W:0] DEPTH_LIM = (WORD_W+1)'(DEPTH);

  state_t            state;
  logic [WORD_W-1:0] len;
  logic [BYTE_W-1:0] hi_byte;
  logic              accept;
  logic              timed_out;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum;
`endif

  assign accept = bus.rx_valid && bus.rx_ready;

  imem_loader_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (busy),
    .expired (timed_out)
  );

  // Load sequencer; every output is registered and set on the transition into its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      bus.rx_ready          <= 1'b0;
      bus.load_address      <= '0;
      bus.instruction_in    <= '0;
      bus.instruction_write <= 1'b0;
      cpu_hold              <= 1'b1;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      error                 <= 1'b0;
      words_loaded          <= '0;
      len                   <= '0;
      hi_byte               <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum                  <= '0;
`endif
    end else begin
      bus.instruction_write <= 1'b0;
      if (timed_out) begin
        state        <= ST_ERROR;
        bus.rx_ready <= 1'b0;
        busy         <= 1'b0;
        error        <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
              state        <= ST_LEN_HI;
              bus.rx_ready <= 1'b1;
              busy         <= 1'b1;
              cpu_hold     <= 1'b1;
              done         <= 1'b0;
              error        <= 1'b0;
              words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum         <= '0;
`endif
            end
          end
          ST_LEN_HI: begin
            if (accept) begin
              len[15:8] <= bus.rx_data;
              state     <= ST_LEN_LO;
            end
          end
          ST_LEN_LO: begin
            if (accept) begin
              len <= {len[15:8], bus.rx_data};
              if (range_end(BASE_ADDR, {len[15:8], bus.rx_data}) > DEPTH_LIM) begin
                state        <= ST_ERROR;
                bus.rx_ready <= 1'b0;
                busy         <= 1'b0;
                error        <= 1'b1;
              end else if ({len[15:8], bus.rx_data} == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state        <= ST_CSUM_HI;
`else
                state        <= ST_DONE;
                bus.rx_ready <= 1'b0;
                busy         <= 1'b0;
                done         <= 1'b1;
                cpu_hold     <= 1'b0;
`endif
              end else begin
                state <= ST_DATA_HI;
              end
            end
          end
          ST_DATA_HI: begin
            if (accept) begin
              hi_byte <= bus.rx_data;
              state   <= ST_DATA_LO;
            end
          end
          ST_DATA_LO: begin
            // Write strobe, address and data are launched together so they
            // are all stable for the single WRITE cycle.
            if (accept) begin
              state                 <= ST_WRITE;
              bus.rx_ready          <= 1'b0;
              bus.instruction_write <= 1'b1;
              bus.load_address      <= BASE_ADDR + words_loaded;
              bus.instruction_in    <= {hi_byte, bus.rx_data};
            end
          end
          ST_WRITE: begin
            words_loaded <= words_loaded + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= csum + bus.instruction_in;
`endif
            if (words_loaded + 16'd1 != len) begin
              state        <= ST_DATA_HI;
              bus.rx_ready <= 1'b1;
            end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state        <= ST_CSUM_HI;
              bus.rx_ready <= 1'b1;
`else
              state        <= ST_DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              cpu_hold     <= 1'b0;
`endif
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          ST_CSUM_HI: begin
            if (accept) begin
              hi_byte <= bus.rx_data;
              state   <= ST_CSUM_LO;
            end
          end
          ST_CSUM_LO: begin
            if (accept) begin
              bus.rx_ready <= 1'b0;
              busy         <= 1'b0;
              if ({hi_byte, bus.rx_data} == csum) begin
                state    <= ST_DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state    <= ST_ERROR;
                error    <= 1'b1;
              end
            end
          end
`endif
          default: begin
            state        <= ST_IDLE;
            bus.rx_ready <= 1'b0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0x0010 and base 0xFFFE),
// both with a 16-cycle idle timeout. Honours IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_hi = 1'b0;
  logic        cpu_hold, busy, done, error;
  logic [15:0] words_loaded;
  logic        cpu_hold_hi, busy_hi, done_hi, error_hi;
  logic [15:0] words_loaded_hi;

  imem_loader_if bus ();
  imem_loader_if bus_hi ();

  always #5 clk = ~clk;

  imem_loader #(
    .BASE_ADDR   (16'h0010),
    .DEPTH       (65536),
    .TIMEOUT_CYC (16)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  imem_loader #(
    .BASE_ADDR   (16'hFFFE),
    .DEPTH       (65536),
    .TIMEOUT_CYC (16)
  ) u_dut_hi (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_hi),
    .bus          (bus_hi),
    .cpu_hold     (cpu_hold_hi),
    .busy         (busy_hi),
    .done         (done_hi),
    .error        (error_hi),
    .words_loaded (words_loaded_hi)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned long_pulses = 0;
  logic        wr_d = 1'b0;
  logic        wr_hi_d = 1'b0;
  logic [31:0] wq[$];
  logic [31:0] wq_hi[$];
  logic [15:0] img[$];

  // Record every write strobe as {address, data} and flag strobes wider than one cycle.
  always @(negedge clk) begin
    if (bus.instruction_write) wq.push_back({bus.load_address, bus.instruction_in});
    if (bus_hi.instruction_write) wq_hi.push_back({bus_hi.load_address, bus_hi.instruction_in});
    wr_d    <= bus.instruction_write;
    wr_hi_d <= bus_hi.instruction_write;
    if ((bus.instruction_write && wr_d) || (bus_hi.instruction_write && wr_hi_d))
      long_pulses <= long_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wq_at(input bit sel, input int unsigned i);
    if (sel) return (i < wq_hi.size()) ? wq_hi[i] : 32'hDEAD_DEAD;
    return (i < wq.size()) ? wq[i] : 32'hDEAD_DEAD;
  endfunction

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input bit sel, input logic [7:0] b);
    int unsigned n = 0;
    if (sel) begin bus_hi.rx_data = b; bus_hi.rx_valid = 1'b1; end
    else     begin bus.rx_data = b;    bus.rx_valid = 1'b1;    end
    while (!(sel ? bus_hi.rx_ready : bus.rx_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("rx_ready_wait", sel ? bus_hi.rx_ready : bus.rx_ready, 1);
    @(negedge clk);
    if (sel) bus_hi.rx_valid = 1'b0;
    else     bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_hi = 1'b1;
    else     start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    start_hi = 1'b0;
  endtask

  task automatic wait_end(input bit sel);
    int unsigned n = 0;
    while (!(sel ? (done_hi || error_hi) : (done || error)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_eq("end_wait", sel ? busy_hi : busy, 0);
  endtask

  task automatic load_image(input bit sel);
    logic [15:0] n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0] sum = '0;
`endif
    n = 16'(img.size());
    pulse_start(sel);
    send_byte(sel, n[15:8]);
    send_byte(sel, n[7:0]);
    foreach (img[i]) begin
      send_byte(sel, img[i][15:8]);
      send_byte(sel, img[i][7:0]);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum = sum + img[i];
`endif
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(sel, sum[15:8]);
    send_byte(sel, sum[7:0]);
`endif
    wait_end(sel);
  endtask

  initial begin
    int unsigned n_before;
    bus.rx_data = '0;    bus.rx_valid = 1'b0;
    bus_hi.rx_data = '0; bus_hi.rx_valid = 1'b0;

    // Reset held for two clocks
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cpu_hold", cpu_hold, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_write", bus.instruction_write, 0);
    check_eq("rst_rx_ready", bus.rx_ready, 0);
    check_eq("rst_words", words_loaded, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word image at base 0x0010
    img = '{16'h1234, 16'hABCD};
    load_image(0);
    check_eq("t2_done", done, 1);
    check_eq("t2_error", error, 0);
    check_eq("t2_cpu_hold", cpu_hold, 0);
    check_eq("t2_busy", busy, 0);
    check_eq("t2_words", words_loaded, 2);
    check_eq("t2_nwrites", wq.size(), 2);
    check_eq("t2_w0", wq_at(0, 0), {16'h0010, 16'h1234});
    check_eq("t2_w1", wq_at(0, 1), {16'h0011, 16'hABCD});

    // Empty image: no writes, done immediately
    pulse_start(0);
    check_eq("t3_done_clr", done, 0);
    check_eq("t3_busy", busy, 1);
    check_eq("t3_cpu_hold", cpu_hold, 1);
    check_eq("t3_rx_ready", bus.rx_ready, 1);
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
`endif
    wait_end(0);
    check_eq("t3_done", done, 1);
    check_eq("t3_words", words_loaded, 0);
    check_eq("t3_nwrites", wq.size(), 2);

    // Exact fit at the top of memory: 0xFFFE + 2 == DEPTH
    img = '{16'h1234, 16'hABCD};
    load_image(1);
    check_eq("fit_done", done_hi, 1);
    check_eq("fit_error", error_hi, 0);
    check_eq("fit_w0", wq_at(1, 0), {16'hFFFE, 16'h1234});
    check_eq("fit_w1", wq_at(1, 1), {16'hFFFF, 16'hABCD});

    // One word too many at the top of memory: rejected at LEN_LO
    pulse_start(1);
    send_byte(1, 8'h00);
    send_byte(1, 8'h03);
    check_eq("t4_error", error_hi, 1);
    check_eq("t4_busy", busy_hi, 0);
    check_eq("t4_cpu_hold", cpu_hold_hi, 1);
    check_eq("t4_done", done_hi, 0);
    check_eq("t4_rx_ready", bus_hi.rx_ready, 0);
    repeat (3) @(negedge clk);
    check_eq("t4_nwrites", wq_hi.size(), 2);
    check_eq("t4_words", words_loaded_hi, 0);

    // Idle timeout mid-word, then a good reload
    pulse_start(0);
    send_byte(0, 8'h00);
    send_byte(0, 8'h04);
    send_byte(0, 8'h12);
    repeat (14) @(negedge clk);
    check_eq("t5_not_early", busy, 1);
    wait_end(0);
    check_eq("t5_error", error, 1);
    check_eq("t5_words", words_loaded, 0);
    check_eq("t5_cpu_hold", cpu_hold, 1);
    check_eq("t5_nwrites", wq.size(), 2);
    img = '{16'h5A5A};
    load_image(0);
    check_eq("t5_reload_done", done, 1);
    check_eq("t5_reload_words", words_loaded, 1);
    check_eq("t5_reload_w", wq_at(0, 2), {16'h0010, 16'h5A5A});

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum trailer: word still written, load fails
    pulse_start(0);
    send_byte(0, 8'h00); send_byte(0, 8'h01);
    send_byte(0, 8'h00); send_byte(0, 8'h05);
    send_byte(0, 8'h00); send_byte(0, 8'h06);
    wait_end(0);
    check_eq("t6_error", error, 1);
    check_eq("t6_done", done, 0);
    check_eq("t6_words", words_loaded, 1);
    check_eq("t6_cpu_hold", cpu_hold, 1);
    check_eq("t6_w", wq_at(0, 3), {16'h0010, 16'h0005});
`endif

    // Reset while the low data byte is being offered
    pulse_start(0);
    send_byte(0, 8'h00);
    send_byte(0, 8'h01);
    send_byte(0, 8'h12);
    n_before = wq.size();
    bus.rx_data = 8'h34;
    bus.rx_valid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_write", bus.instruction_write, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_rx_ready", bus.rx_ready, 0);
    check_eq("mid_rst_cpu_hold", cpu_hold, 1);
    rst_n = 1'b1;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_rst_nwrites", wq.size(), n_before);
    check_eq("mid_rst_idle", busy, 0);
    check_eq("write_pulse_width", long_pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

endmodule
